caf_peak_scheduler: RTL and testbench

Sequences the argmax block across all Doppler/frequency bins of a CAF search. For each bin it gates exactly buffer_length correlation samples from the correlator into argmax and waits for argmax's result pulse. It keeps a running global peak and reports the best magnitude, time index and frequency bin when the sweep completes. It sits between the correlator output stream and argmax and drives the correlator's bin select.

---
 rtl/caf_peak_scheduler.sv | 178 +++++++++++++++++
 tb/tb_caf_peak_scheduler.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/caf_peak_scheduler.sv
// caf_peak_scheduler: walks the argmax block across every frequency bin of a
// CAF search, gating one buffer of correlator samples per bin into argmax,
// collecting its per-bin result and keeping the global peak over the sweep.
//
// state     | meaning
// ----------+--------------------------------------------------------------
// S_IDLE    | waiting for start; best_* hold the previous sweep's result
// S_STREAM  | gating buffer_length samples of bin bin_sel into argmax
// S_WAIT    | buffer delivered, waiting for argmax result (timeout guarded)
// S_COMPARE | fold latched bin result into the global peak, advance bin
// S_DONE    | one-cycle done (and error on timeout) pulse, back to idle
module caf_peak_scheduler #(
    parameter int buffer_length  = 10,
    parameter int index_bits     = 4,
    parameter int out_max_bits   = 4,
    parameter int i_bits         = 12,
    parameter int q_bits         = 12,
    parameter int num_bins       = 8,
    parameter int bin_bits       = 3,
    parameter int timeout_cycles = 64,
    parameter int timeout_bits   = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    error,
    output logic [bin_bits-1:0]     bin_sel,
    input  logic                    in_tvalid,
    input  logic [i_bits-1:0]       in_xi,
    input  logic [q_bits-1:0]       in_xq,
    output logic                    in_tready,
    output logic                    am_tvalid,
    output logic [i_bits-1:0]       am_xi,
    output logic [q_bits-1:0]       am_xq,
    output logic                    am_ready,
    input  logic                    am_sready,
    input  logic                    am_rvalid,
    input  logic [out_max_bits-1:0] am_out_max,
    input  logic [index_bits-1:0]   am_index,
    output logic [out_max_bits-1:0] best_max,
    output logic [index_bits-1:0]   best_index,
    output logic [bin_bits-1:0]     best_bin
);

    localparam int CNT_W = $clog2(buffer_length + 1);
    localparam logic [CNT_W-1:0]        CNT_LAST = CNT_W'(buffer_length - 1);
    localparam logic [CNT_W-1:0]        CNT_FULL = CNT_W'(buffer_length);
    localparam logic [timeout_bits-1:0] TMO_LAST = timeout_bits'(timeout_cycles - 1);
    localparam logic [bin_bits-1:0]     BIN_LAST = bin_bits'(num_bins - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_STREAM,
        S_WAIT,
        S_COMPARE,
        S_DONE
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [timeout_bits-1:0] tmo_q;
    logic [bin_bits-1:0]     bin_q;
    logic                    busy_q;
    logic                    done_q;
    logic                    error_q;
    logic [out_max_bits-1:0] lat_max_q;
    logic [index_bits-1:0]   lat_idx_q;
    logic [out_max_bits-1:0] best_max_q;
    logic [index_bits-1:0]   best_idx_q;
    logic [bin_bits-1:0]     best_bin_q;

    logic gate_open;
    logic accept;

    // Sample gate: the handshake is a straight pass-through between correlator
    // and argmax, closed once the bin's buffer has been filled.
    assign gate_open = (state_q == S_STREAM) && (cnt_q < CNT_FULL);
    assign in_tready = gate_open & am_sready;
    assign am_tvalid = gate_open & in_tvalid;
    assign accept    = in_tvalid & in_tready;
    assign am_xi     = in_xi;
    assign am_xq     = in_xq;
    // Held through WAIT so argmax can drain its result and wrap its counter.
    assign am_ready  = (state_q == S_STREAM) || (state_q == S_WAIT);

    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = error_q;
    assign bin_sel    = bin_q;
    assign best_max   = best_max_q;
    assign best_index = best_idx_q;
    assign best_bin   = best_bin_q;

    // Sweep sequencer: per-bin stream/wait/compare loop with registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            tmo_q      <= '0;
            bin_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 1'b0;
            lat_max_q  <= '0;
            lat_idx_q  <= '0;
            best_max_q <= '0;
            best_idx_q <= '0;
            best_bin_q <= '0;
        end else begin
            done_q  <= 1'b0;
            error_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q    <= S_STREAM;
                        busy_q     <= 1'b1;
                        bin_q      <= '0;
                        cnt_q      <= '0;
                        tmo_q      <= '0;
                        best_max_q <= '0;
                        best_idx_q <= '0;
                        best_bin_q <= '0;
                    end
                end
                S_STREAM: begin
                    if (accept) begin
                        if (cnt_q == CNT_LAST) begin
                            cnt_q   <= '0;
                            tmo_q   <= '0;
                            state_q <= S_WAIT;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end
                S_WAIT: begin
                    if (am_rvalid) begin
                        lat_max_q <= am_out_max;
                        lat_idx_q <= am_index;
                        state_q   <= S_COMPARE;
                    end else if (tmo_q == TMO_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        error_q <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        tmo_q <= tmo_q + timeout_bits'(1);
                    end
                end
                S_COMPARE: begin
                    // Strictly greater: on a tie the earlier bin/index is kept.
                    if (lat_max_q > best_max_q) begin
                        best_max_q <= lat_max_q;
                        best_idx_q <= lat_idx_q;
                        best_bin_q <= bin_q;
                    end
                    if (bin_q == BIN_LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end else begin
                        bin_q   <= bin_q + bin_bits'(1);
                        state_q <= S_STREAM;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_caf_peak_scheduler.sv
// Directed bench for caf_peak_scheduler with behavioural correlator and
// argmax stand-ins (argmax magnitude = in_xi[11:8], first strict max wins).
module tb_caf_peak_scheduler;

    localparam int NB = 4;
    localparam int BL = 10;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        busy, done, error;
    logic [1:0]  bin_sel;
    logic        in_tvalid = 1'b0;
    logic [11:0] in_xi = '0;
    logic [11:0] in_xq = '0;
    logic        in_tready;
    logic        am_tvalid;
    logic [11:0] am_xi, am_xq;
    logic        am_ready;
    logic        am_sready = 1'b1;
    logic        am_rvalid = 1'b0;
    logic [3:0]  am_out_max = '0;
    logic [3:0]  am_index = '0;
    logic [3:0]  best_max, best_index;
    logic [1:0]  best_bin;

    caf_peak_scheduler #(
        .buffer_length(BL), .index_bits(4), .out_max_bits(4), .i_bits(12),
        .q_bits(12), .num_bins(NB), .bin_bits(2), .timeout_cycles(64), .timeout_bits(7)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .error(error),
        .bin_sel(bin_sel), .in_tvalid(in_tvalid), .in_xi(in_xi), .in_xq(in_xq),
        .in_tready(in_tready), .am_tvalid(am_tvalid), .am_xi(am_xi), .am_xq(am_xq),
        .am_ready(am_ready), .am_sready(am_sready), .am_rvalid(am_rvalid),
        .am_out_max(am_out_max), .am_index(am_index), .best_max(best_max),
        .best_index(best_index), .best_bin(best_bin)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    logic [11:0] data_xi [0:NB-1][0:BL-1];
    int   corr_cnt = 0, am_cnt = 0, rv_delay = 0, cyc = 0, wcnt = 0;
    int   hs_bin [0:NB-1];
    int   done_cnt = 0, wait_at_done = 0, sready_viol = 0, pt_err = 0;
    logic err_at_done = 1'b0, busy_at_done = 1'b0;
    logic [3:0] am_best = '0, am_bidx = '0, rv_max = '0, rv_idx = '0;
    bit   tog_mode = 1'b0;
    int   suppress_bin = -1;

    // Correlator/argmax stand-ins and monitors; inputs change on the falling edge.
    always @(negedge clk) begin
        cyc++;
        wcnt++;
        am_rvalid = 1'b0;
        if (rv_delay > 0) begin
            rv_delay--;
            if (rv_delay == 0 && int'(bin_sel) != suppress_bin) am_rvalid = 1'b1;
        end
        am_out_max = rv_max;
        am_index   = rv_idx;
        in_tvalid  = tog_mode ? ~in_tvalid : 1'b1;
        am_sready  = !(tog_mode && (cyc % 20) >= 5 && (cyc % 20) < 8);
        in_xi      = (corr_cnt < BL) ? data_xi[bin_sel][corr_cnt] : 12'h000;
        #1;
        if (!busy) begin
            corr_cnt = 0; am_cnt = 0; am_best = '0; am_bidx = '0; rv_delay = 0;
        end else if (in_tvalid && in_tready) begin
            if (!am_sready) sready_viol++;
            if (am_xi !== in_xi || am_xq !== in_xq || !am_tvalid || !am_ready) pt_err++;
            hs_bin[bin_sel]++;
            if (in_xi[11:8] > am_best) begin
                am_best = in_xi[11:8];
                am_bidx = am_cnt[3:0];
            end
            am_cnt++;
            corr_cnt++;
            if (am_cnt == BL) begin
                rv_max = am_best; rv_idx = am_bidx; rv_delay = 2;
                am_cnt = 0; corr_cnt = 0; am_best = '0; am_bidx = '0; wcnt = 0;
            end
        end
        if (done) begin
            done_cnt++;
            err_at_done  = error;
            busy_at_done = busy;
            wait_at_done = wcnt;
        end
    end

    task automatic clear_data();
        for (int b = 0; b < NB; b++)
            for (int s = 0; s < BL; s++) data_xi[b][s] = 12'h000;
        tog_mode = 1'b0;
        suppress_bin = -1;
    endtask

    task automatic run_sweep(input bit poke);
        int i;
        for (int b = 0; b < NB; b++) hs_bin[b] = 0;
        done_cnt = 0; sready_viol = 0; pt_err = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (i = 0; i < 3000 && done_cnt == 0; i++) begin
            @(negedge clk);
            start = poke && (i == 15 || i == 40);
        end
        start = 1'b0;
        tests++;
        if (done_cnt == 0) begin
            fails++;
            $display("FAIL sweep_timeout: no done after %0d cycles, required done", i);
        end
        repeat (5) @(negedge clk);
    endtask

    task automatic check_hs();
        for (int b = 0; b < NB; b++) begin
            tests++;
            if (hs_bin[b] != BL) begin
                fails++;
                $display("FAIL hs_bin%0d: got %0d handshakes, required %0d", b, hs_bin[b], BL);
            end
        end
    endtask

    task automatic check_result(input string tag, input logic [3:0] emax,
                                input logic [3:0] eidx, input logic [1:0] ebin, input logic eerr);
        tests++;
        if (done_cnt != 1) begin fails++; $display("FAIL %s done_count: got %0d required 1", tag, done_cnt); end
        tests++;
        if (err_at_done !== eerr) begin fails++; $display("FAIL %s error: got %b required %b", tag, err_at_done, eerr); end
        tests++;
        if (busy_at_done !== 1'b0) begin fails++; $display("FAIL %s busy_at_done: got %b required 0", tag, busy_at_done); end
        tests++;
        if (best_max !== emax) begin fails++; $display("FAIL %s best_max: got %0d required %0d", tag, best_max, emax); end
        tests++;
        if (best_index !== eidx) begin fails++; $display("FAIL %s best_index: got %0d required %0d", tag, best_index, eidx); end
        tests++;
        if (best_bin !== ebin) begin fails++; $display("FAIL %s best_bin: got %0d required %0d", tag, best_bin, ebin); end
        tests++;
        if (busy !== 1'b0 || done !== 1'b0 || error !== 1'b0) begin
            fails++;
            $display("FAIL %s idle_after: busy=%b done=%b error=%b required 0 0 0", tag, busy, done, error);
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        tests++;
        if ({busy, done, error, in_tready, am_tvalid, am_ready} !== 6'b0) begin
            fails++;
            $display("FAIL %s ctrl: got busy=%b done=%b error=%b in_tready=%b am_tvalid=%b am_ready=%b required all 0",
                     tag, busy, done, error, in_tready, am_tvalid, am_ready);
        end
        tests++;
        if ({bin_sel, best_max, best_index, best_bin} !== 12'h000) begin
            fails++;
            $display("FAIL %s data: got bin_sel=%0d best_max=%0d best_index=%0d best_bin=%0d required all 0",
                     tag, bin_sel, best_max, best_index, best_bin);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check_idle_outputs("reset");
        rst = 1'b0;
        repeat (2) @(negedge clk);
        check_idle_outputs("reset_idle");
    endtask

    task automatic test_single_peak();
        clear_data();
        data_xi[2][6] = 12'h400;
        run_sweep(1'b0);
        check_result("single_peak", 4'd4, 4'd6, 2'd2, 1'b0);
        check_hs();
        tests++;
        if (pt_err != 0) begin fails++; $display("FAIL passthrough: got %0d bad handshakes required 0", pt_err); end
    endtask

    task automatic test_all_zero();
        clear_data();
        run_sweep(1'b0);
        check_result("all_zero", 4'd0, 4'd0, 2'd0, 1'b0);
    endtask

    task automatic test_tie();
        clear_data();
        data_xi[0][0] = 12'h200;
        data_xi[1][3] = 12'h500;
        data_xi[3][8] = 12'h5FF;
        run_sweep(1'b0);
        check_result("tie", 4'd5, 4'd3, 2'd1, 1'b0);
    endtask

    task automatic test_backpressure();
        clear_data();
        tog_mode = 1'b1;
        data_xi[0][9] = 12'h700;
        data_xi[3][0] = 12'h300;
        run_sweep(1'b0);
        check_result("backpressure", 4'd7, 4'd9, 2'd0, 1'b0);
        check_hs();
        tests++;
        if (sready_viol != 0) begin fails++; $display("FAIL sready_gate: got %0d accepts with am_sready low required 0", sready_viol); end
        tog_mode = 1'b0;
    endtask

    task automatic test_timeout();
        clear_data();
        suppress_bin = 1;
        data_xi[0][2] = 12'h600;
        data_xi[2][1] = 12'h700;
        run_sweep(1'b0);
        check_result("timeout", 4'd6, 4'd2, 2'd0, 1'b1);
        tests++;
        if (wait_at_done != 65) begin
            fails++;
            $display("FAIL timeout_latency: done seen %0d cycles after last sample, required 65", wait_at_done);
        end
        suppress_bin = -1;
    endtask

    task automatic test_reset_mid_sweep();
        int i;
        clear_data();
        data_xi[2][6] = 12'h400;
        done_cnt = 0;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        for (i = 0; i < 1000 && bin_sel != 2'd2; i++) @(negedge clk);
        tests++;
        if (bin_sel != 2'd2) begin fails++; $display("FAIL reach_bin2: got bin_sel=%0d required 2", bin_sel); end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_idle_outputs("mid_reset");
        repeat (100) @(negedge clk);
        tests++;
        if (done_cnt != 0) begin fails++; $display("FAIL mid_reset_done: got %0d done pulses required 0", done_cnt); end
        run_sweep(1'b0);
        check_result("after_reset", 4'd4, 4'd6, 2'd2, 1'b0);
        check_hs();
    endtask

    task automatic test_start_while_busy();
        clear_data();
        data_xi[3][4] = 12'h7C0;
        run_sweep(1'b1);
        repeat (30) @(negedge clk);
        check_result("start_busy", 4'd7, 4'd4, 2'd3, 1'b0);
    endtask

    initial begin
        test_reset();
        test_single_peak();
        test_all_zero();
        test_tie();
        test_backpressure();
        test_timeout();
        test_reset_mid_sweep();
        test_start_while_busy();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
